md_issue_ctrl: RTL and testbench

// - E-stage issue controller directly upstream of the multiply/divide unit.
// - Decodes the E-stage mult/div/mthi/mtlo/mfhi/mflo class and drives the unit's Start/Op/We/HiLo.
// - Tracks the unit's busy window and raises Stall to the hazard unit.
// - Guarantees each instruction fires at most one Start or We, including under external stalls and flushes.

---
 rtl/md_pkg.sv | 40 ++++
 rtl/md_issue_ctrl_if.sv | 31 +++
 rtl/md_issue_ctrl.sv | 83 ++++++++
 tb/tb_md_issue_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module  : md_pkg
// Brief   : Encodings shared by the multiply/divide issue controller.
// Revision: 1.0 - initial release
// ============================================================================
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULTU = 4'd1;
    localparam logic [3:0] MD_MULT  = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_DIV   = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    function automatic logic is_md(input logic [3:0] cls);
        return (cls >= MD_MULTU) && (cls <= MD_MFLO);
    endfunction

    function automatic logic is_muldiv(input logic [3:0] cls);
        return (cls >= MD_MULTU) && (cls <= MD_DIV);
    endfunction

    function automatic logic is_mt(input logic [3:0] cls);
        return (cls == MD_MTHI) || (cls == MD_MTLO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : md_issue_ctrl_if
// Brief   : E-stage / multiply-divide unit handshake bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface md_issue_ctrl_if;

    logic [3:0] e_md_cls;
    logic       e_flush;
    logic       ext_stall;
    logic       busy;
    logic       start;
    logic [1:0] op;
    logic       we;
    logic       hilo;
    logic       stall;
    logic       wd_err;

    modport master (
        output e_md_cls, e_flush, ext_stall, busy,
        input  start, op, we, hilo, stall, wd_err
    );

    modport slave (
        input  e_md_cls, e_flush, ext_stall, busy,
        output start, op, we, hilo, stall, wd_err
    );

endinterface
`default_nettype wire

// File: rtl/md_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : md_issue_ctrl
// Brief   : E-stage issue control, busy tracking and watchdog for the md unit.
// Revision: 1.0 - initial release
// ============================================================================
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MAX_LAT = 12,
    parameter int CNT_W   = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    md_issue_ctrl_if.slave  md
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MAX_LAT - 1);

    logic [0:0]       r_state;
    logic             r_issued;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wd_err;

    logic             w_idle_ok;
    logic             w_start;
    logic             w_we;
    logic [3:0]       w_cls_m1;

    assign w_idle_ok = (r_state == ST_IDLE) && !r_issued && !md.e_flush;
    assign w_start   = is_muldiv(md.e_md_cls) && w_idle_ok;
    assign w_we      = is_mt(md.e_md_cls) && w_idle_ok;
    assign w_cls_m1  = md.e_md_cls - 4'd1;

    assign md.start  = w_start;
    assign md.we     = w_we;
    assign md.op     = w_start ? w_cls_m1[1:0] : OP_MULTU;
    assign md.hilo   = (md.e_md_cls == MD_MTHI) || (md.e_md_cls == MD_MFHI);
    // The Busy=0 cycle in RUN is the completion cycle: Hi/Lo are already valid.
    assign md.stall  = is_md(md.e_md_cls) && (r_state == ST_RUN) && md.busy && !r_issued;
    assign md.wd_err = r_wd_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_wd_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (!md.busy) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state  <= ST_IDLE;
                        r_wd_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Remembers that the instruction held in E has already fired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued <= 1'b0;
        end else if (md.e_flush || !md.ext_stall) begin
            r_issued <= 1'b0;
        end else if (w_start || w_we) begin
            r_issued <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_md_issue_ctrl
// Brief   : Self-checking bench for md_issue_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_md_issue_ctrl;

    typedef struct packed {
        logic [3:0] cls;
        logic       flush;
        logic       ext;
        logic       busy;
        logic [6:0] exp;   // {start, op[1:0], we, hilo, stall, wd_err}
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [6:0] sb_q[$];
    string      nm_q[$];
    vec_t       tbl[$];

    md_issue_ctrl_if u_if ();

    md_issue_ctrl #(.MAX_LAT(12), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (u_if.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] cls, input logic fl, input logic ex,
                                input logic bz, input logic st, input logic [1:0] op,
                                input logic we, input logic hl, input logic sl, input logic wd);
        vec_t v;
        v.cls = cls; v.flush = fl; v.ext = ex; v.busy = bz;
        v.exp = {st, op, we, hl, sl, wd};
        return v;
    endfunction

    task automatic drive(input vec_t v, input string nm);
        u_if.e_md_cls  = v.cls;
        u_if.e_flush   = v.flush;
        u_if.ext_stall = v.ext;
        u_if.busy      = v.busy;
        sb_q.push_back(v.exp);
        nm_q.push_back(nm);
    endtask

    task automatic sample();
        logic [6:0] e;
        logic [6:0] a;
        string      n;
        e = sb_q.pop_front();
        n = nm_q.pop_front();
        a = {u_if.start, u_if.op, u_if.we, u_if.hilo, u_if.stall, u_if.wd_err};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got {start,op,we,hilo,stall,wderr}=%b expected %b", n, a, e);
        end
    endtask

    task automatic step(input vec_t v, input string nm);
        @(posedge clk);
        #1;
        drive(v, nm);
        @(negedge clk);
        sample();
    endtask

    initial begin
        u_if.e_md_cls  = 4'd0;
        u_if.e_flush   = 1'b0;
        u_if.ext_stall = 1'b0;
        u_if.busy      = 1'bx;

        //               cls  fl  ex  bz    st op    we  hl  sl  wd
        tbl.push_back(mk(4'd0,0, 0, 1'bx, 0, 2'b00, 0, 0, 0, 0)); // reset idle
        tbl.push_back(mk(4'd5,1, 0, 0,    0, 2'b00, 0, 1, 0, 0)); // mthi flushed
        tbl.push_back(mk(4'd5,0, 0, 0,    0, 2'b00, 1, 1, 0, 0)); // mthi
        tbl.push_back(mk(4'd6,0, 0, 0,    0, 2'b00, 1, 0, 0, 0)); // mtlo
        tbl.push_back(mk(4'd7,0, 0, 0,    0, 2'b00, 0, 1, 0, 0)); // mfhi idle
        tbl.push_back(mk(4'd5,0, 1, 0,    0, 2'b00, 1, 1, 0, 0)); // mthi extstall fire
        tbl.push_back(mk(4'd5,0, 1, 0,    0, 2'b00, 0, 1, 0, 0)); // mthi held
        tbl.push_back(mk(4'd5,0, 0, 0,    0, 2'b00, 0, 1, 0, 0)); // mthi last hold
        tbl.push_back(mk(4'd2,0, 0, 1'bx, 1, 2'b01, 0, 0, 0, 0)); // mult start
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(4'd8,0, 0, 1, 0, 2'b00, 0, 0, 1, 0));  // mflo stalled
        tbl.push_back(mk(4'd8,0, 0, 0,    0, 2'b00, 0, 0, 0, 0)); // mflo done
        tbl.push_back(mk(4'd0,0, 0, 0,    0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(4'd4,0, 1, 1'bx, 1, 2'b11, 0, 0, 0, 0)); // div start under ext
        tbl.push_back(mk(4'd4,0, 1, 1,    0, 2'b00, 0, 0, 0, 0)); // div held, no self stall
        tbl.push_back(mk(4'd4,0, 1, 1,    0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(4'd4,0, 0, 1,    0, 2'b00, 0, 0, 0, 0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(4'd3,0, 0, 1, 0, 2'b00, 0, 0, 1, 0));  // divu stalled
        tbl.push_back(mk(4'd3,0, 0, 0,    0, 2'b00, 0, 0, 0, 0)); // div done
        tbl.push_back(mk(4'd3,0, 0, 1'bx, 1, 2'b10, 0, 0, 0, 0)); // divu start
        tbl.push_back(mk(4'd8,1, 0, 1,    0, 2'b00, 0, 0, 1, 0)); // flush in RUN
        tbl.push_back(mk(4'd0,0, 0, 1,    0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(4'd0,0, 0, 0,    0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(4'd1,0, 0, 1'bx, 1, 2'b00, 0, 0, 0, 0)); // multu start

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // watchdog: Busy never drops after the multu above
        for (int i = 0; i < 12; i++)
            step(mk(4'd7,0,0,1, 0,2'b00,0,1,1,0), $sformatf("wd_run%0d", i));
        step(mk(4'd7,0,0,1, 0,2'b00,0,1,0,1), "wd_trip");
        step(mk(4'd0,0,0,1, 0,2'b00,0,0,0,1), "wd_sticky0");
        step(mk(4'd2,0,0,0, 1,2'b01,0,0,0,1), "wd_sticky_mult");
        step(mk(4'd0,0,0,0, 0,2'b00,0,0,0,1), "wd_sticky1");

        // asynchronous reset during RUN
        step(mk(4'd2,0,0,0, 1,2'b01,0,0,0,1), "ar_start");
        for (int i = 1; i <= 3; i++)
            step(mk(4'd8,0,0,1, 0,2'b00,0,0,1,1), $sformatf("ar_run%0d", i));
        rst_n = 1'b0;
        #1;
        drive(mk(4'd8,0,0,1, 0,2'b00,0,0,0,0), "ar_async");
        sample();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        step(mk(4'd8,0,0,1, 0,2'b00,0,0,0,0), "ar_after");
        step(mk(4'd4,0,0,1, 1,2'b11,0,0,0,0), "ar_restart");

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
